square_draw_ctrl: RTL and testbench

- Consumer side of the square pixel-scan counters. Accepts one draw request (origin, square size, colour) through a valid/ready handshake.
- Scans every pixel of a 4x4, 10x10 or 20x20 square and drives VGA-adapter write signals (x, y, colour, plot), clipping to screen.
- Pulses done when the square is finished. Sits between the game-board renderer and the VGA adapter.

---
 rtl/draw_pkg.sv | 34 +++
 rtl/square_scan.sv | 61 ++++++
 rtl/square_draw_ctrl.sv | 131 +++++++++++++
 tb/tb_square_draw_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the square drawing path.
// Contents:
//   - request size codes (2-bit) and the side length each code selects
//   - draw controller state encoding
//   - side_of(): size code -> side length in pixels (0 for the null code)
package draw_pkg;

   localparam logic [1:0] SIZE_SMALL  = 2'd0;
   localparam logic [1:0] SIZE_MEDIUM = 2'd1;
   localparam logic [1:0] SIZE_BIG    = 2'd2;
   localparam logic [1:0] SIZE_NULL   = 2'd3;

   localparam logic [4:0] SIDE_SMALL  = 5'd4;
   localparam logic [4:0] SIDE_MEDIUM = 5'd10;
   localparam logic [4:0] SIDE_BIG    = 5'd20;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StDraw = 2'd1,
      StDone = 2'd2
   } draw_state_e;

   function automatic logic [4:0] side_of(input logic [1:0] size);
      logic [4:0] side;
      unique case (size)
         SIZE_SMALL:  side = SIDE_SMALL;
         SIZE_MEDIUM: side = SIDE_MEDIUM;
         SIZE_BIG:    side = SIDE_BIG;
         default:     side = 5'd0;
      endcase
      return side;
   endfunction

endpackage

// File: rtl/square_scan.sv
// Column/row scan counter for a square of runtime side length.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   side_i          side length N (5-bit); must be stable while advancing
//   clear_i         force col=row=0 (has priority over advance_i)
//   advance_i       step one pixel, row-major, col fastest
//   col_o, row_o    current pixel offsets, always within 0..N-1
//   last_o          current pixel is the final one (col==N-1 && row==N-1)
module square_scan (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [4:0] side_i,
   input  logic       clear_i,
   input  logic       advance_i,
   output logic [4:0] col_o,
   output logic [4:0] row_o,
   output logic       last_o
);

   logic [4:0] col_q, col_d;
   logic [4:0] row_q, row_d;
   logic [4:0] side_m1;
   logic       col_end;
   logic       row_end;

   assign side_m1 = side_i - 5'd1;
   assign col_end = (col_q == side_m1);
   assign row_end = (row_q == side_m1);

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clear_i) begin
         col_d = 5'd0;
         row_d = 5'd0;
      end else if (advance_i) begin
         if (col_end) begin
            col_d = 5'd0;
            // Fold back to the origin after the final pixel so row never reaches N.
            row_d = row_end ? 5'd0 : row_q + 5'd1;
         end else begin
            col_d = col_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q <= 5'd0;
         row_q <= 5'd0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign last_o = col_end && row_end;

endmodule

// File: rtl/square_draw_ctrl.sv
// Square draw controller: accepts one draw request (origin, size, colour) via
// valid/ready, scans every pixel of the square one per cycle and drives the VGA
// adapter write port, suppressing plots that fall off screen. Pulses done once
// the square is finished.
// Ports:
//   clock, resetn                 clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (ready only while idle)
//   req_x, req_y                  top-left origin of the square
//   req_size                      0=4x4, 1=10x10, 2=20x20, 3=null (no pixels)
//   req_colour                    fill colour
//   vga_x, vga_y, vga_colour      pixel to write
//   vga_plot                      write strobe, only for on-screen pixels
//   busy                          drawing or finishing
//   done                          one-cycle pulse on completion
// All outputs depend on registered state only.
module square_draw_ctrl
   import draw_pkg::*;
#(
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120,
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned COLOUR_W = 3
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [X_W-1:0]      req_x,
   input  logic [Y_W-1:0]      req_y,
   input  logic [1:0]          req_size,
   input  logic [COLOUR_W-1:0] req_colour,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   output logic                busy,
   output logic                done
);

   localparam logic [X_W:0] XLim = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] YLim = (Y_W+1)'(SCREEN_H);

   draw_state_e         state_q, state_d;
   logic [X_W-1:0]      origin_x_q, origin_x_d;
   logic [Y_W-1:0]      origin_y_q, origin_y_d;
   logic [1:0]          size_q, size_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;

   logic                accept;
   logic [4:0]          col;
   logic [4:0]          row;
   logic                last;
   logic [X_W:0]        x_sum;
   logic [Y_W:0]        y_sum;

   assign accept = req_valid && (state_q == StIdle);

   square_scan u_scan (
      .clk_i     (clock),
      .rst_ni    (resetn),
      .side_i    (side_of(size_q)),
      .clear_i   (accept),
      .advance_i (state_q == StDraw),
      .col_o     (col),
      .row_o     (row),
      .last_o    (last)
   );

   // One extra bit so an origin near the top of the coordinate range cannot wrap
   // back on screen.
   assign x_sum = (X_W+1)'(origin_x_q) + (X_W+1)'(col);
   assign y_sum = (Y_W+1)'(origin_y_q) + (Y_W+1)'(row);

   always_comb begin
      state_d    = state_q;
      origin_x_d = origin_x_q;
      origin_y_d = origin_y_q;
      size_d     = size_q;
      colour_d   = colour_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               origin_x_d = req_x;
               origin_y_d = req_y;
               size_d     = req_size;
               colour_d   = req_colour;
               state_d    = (req_size == SIZE_NULL) ? StDone : StDraw;
            end
         end
         StDraw: begin
            if (last) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         origin_x_q <= '0;
         origin_y_q <= '0;
         size_q     <= '0;
         colour_q   <= '0;
      end else begin
         state_q    <= state_d;
         origin_x_q <= origin_x_d;
         origin_y_q <= origin_y_d;
         size_q     <= size_d;
         colour_q   <= colour_d;
      end
   end

   always_comb begin
      req_ready  = (state_q == StIdle);
      busy       = (state_q == StDraw) || (state_q == StDone);
      done       = (state_q == StDone);
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      if (state_q == StDraw) begin
         vga_x      = x_sum[X_W-1:0];
         vga_y      = y_sum[Y_W-1:0];
         vga_colour = colour_q;
         vga_plot   = (x_sum < XLim) && (y_sum < YLim);
      end
   end

endmodule

// File: tb/tb_square_draw_ctrl.sv
// Directed bench for square_draw_ctrl: each request pushes its expected
// per-cycle output records into a scoreboard queue, which is drained and
// compared one record per cycle at the falling edge.
module tb_square_draw_ctrl;

   logic       clock = 1'b0;
   logic       resetn;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_x;
   logic [6:0] req_y;
   logic [1:0] req_size;
   logic [2:0] req_colour;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       pix;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic       plot;
      logic       done;
      logic       busy;
      logic       ready;
   } exp_t;

   exp_t sb[$];

   square_draw_ctrl dut (
      .clock      (clock),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_size   (req_size),
      .req_colour (req_colour),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Called at a falling edge; returns at a falling edge after the square's
   // records (pixels, done, first idle cycle) have all been compared.
   task automatic run_square(input int ix, input int iy, input logic [1:0] isz,
                             input logic [2:0] icol, input bit hold, input int exp_plots);
      int   side;
      int   waited;
      int   plots;
      int   busy_cyc;
      int   sx;
      int   sy;
      exp_t e;
      req_x      = 8'(ix);
      req_y      = 7'(iy);
      req_size   = isz;
      req_colour = icol;
      req_valid  = 1'b1;
      waited     = 0;
      while (!req_ready && waited < 2000) begin
         @(negedge clock);
         waited++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      if (!hold) req_valid = 1'b0;
      side = (isz == 2'd0) ? 4 : (isz == 2'd1) ? 10 : (isz == 2'd2) ? 20 : 0;
      for (int r = 0; r < side; r++) begin
         for (int c = 0; c < side; c++) begin
            sx     = ix + c;
            sy     = iy + r;
            e.pix  = 1'b1;
            e.x    = 8'(sx);
            e.y    = 7'(sy);
            e.c    = icol;
            e.plot = (sx < 160) && (sy < 120);
            e.done = 1'b0;
            e.busy = 1'b1;
            e.ready = 1'b0;
            sb.push_back(e);
         end
      end
      e = '{pix: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, plot: 1'b0, done: 1'b1, busy: 1'b1,
            ready: 1'b0};
      sb.push_back(e);
      e = '{pix: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, plot: 1'b0, done: 1'b0, busy: 1'b0,
            ready: 1'b1};
      sb.push_back(e);
      plots    = 0;
      busy_cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clock);
         e = sb.pop_front();
         // Scramble the held request while busy; it must not disturb the square.
         if (hold && e.busy) begin
            req_x      = 8'($urandom);
            req_y      = 7'($urandom);
            req_colour = 3'($urandom);
            req_size   = 2'($urandom);
         end
         chk("plot", vga_plot, e.plot);
         chk("done", done, e.done);
         chk("busy", busy, e.busy);
         chk("req_ready", req_ready, e.ready);
         if (e.pix) begin
            chk("vga_x", vga_x, e.x);
            chk("vga_y", vga_y, e.y);
            chk("vga_colour", vga_colour, e.c);
         end
         if (vga_plot) plots++;
         if (busy) busy_cyc++;
      end
      chk("plot_count", plots, exp_plots);
      chk("busy_cycles", busy_cyc, side * side + 1);
   endtask

   initial begin
      resetn     = 1'b0;
      req_valid  = 1'b0;
      req_x      = '0;
      req_y      = '0;
      req_size   = '0;
      req_colour = '0;
      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_plot", vga_plot, 0);
      chk("rst_done", done, 0);
      chk("rst_x", vga_x, 0);
      chk("rst_y", vga_y, 0);
      chk("rst_colour", vga_colour, 0);
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("idle_ready", req_ready, 1);
         chk("idle_busy", busy, 0);
         chk("idle_plot", vga_plot, 0);
         chk("idle_done", done, 0);
      end

      run_square(10, 20, 2'd0, 3'd5, 1'b0, 16);
      run_square(150, 110, 2'd2, 3'd2, 1'b0, 100);
      run_square(40, 40, 2'd1, 3'd4, 1'b1, 100);
      run_square(40, 40, 2'd1, 3'd4, 1'b0, 100);
      run_square(0, 0, 2'd3, 3'd7, 1'b0, 0);

      // Reset in the middle of a big square.
      req_x      = 8'd30;
      req_y      = 7'd30;
      req_size   = 2'd2;
      req_colour = 3'd6;
      req_valid  = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      repeat (50) @(negedge clock);
      chk("mid_plot", vga_plot, 1);
      chk("mid_x", vga_x, 39);
      chk("mid_y", vga_y, 32);
      #2;
      resetn = 1'b0;
      #1;
      chk("async_plot", vga_plot, 0);
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      chk("async_ready", req_ready, 1);
      repeat (2) begin
         @(negedge clock);
         chk("rst_hold_done", done, 0);
      end
      resetn = 1'b1;
      @(negedge clock);
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
      run_square(5, 5, 2'd0, 3'd3, 1'b0, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
